// File: rtl/divider_bus_if_pkg.sv
// rtl/divider_bus_if_pkg.sv - register map, FSM encoding and STATUS layout for divider_bus_if
package divider_bus_if_pkg;

  localparam logic [1:0] ADDR_DIVIDEND = 2'd0;
  localparam logic [1:0] ADDR_DIVISOR  = 2'd1;
  localparam logic [1:0] ADDR_QUOTIENT = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DBZ  = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WACK   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/divider_bus_if.sv
// rtl/divider_bus_if.sv - IO-bus register front end driving the fixed-point divider
// Every output is a flop; the comb process computes next values for state and outputs together.
module divider_bus_if
  import divider_bus_if_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             div_write_a,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_val
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] quo, quo_nx;
  logic             ovf, ovf_nx, dbz, dbz_nx, busy_flag, busy_nx;
  logic [WIDTH-1:0] q_nx, div_a_nx, div_b_nx;
  logic             done_nx, write_a_nx, start_nx;
  logic [WIDTH-1:0] status_word;

  // The bus stalls on busy_flag instead, so the divider's own busy is not needed.
  logic unused_div_busy;
  assign unused_div_busy = div_busy;

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = busy_flag;
    status_word[STAT_DBZ]  = dbz;
    status_word[STAT_OVF]  = ovf;
  end

  always_comb begin
    state_nx   = state;
    q_nx       = q;
    div_a_nx   = div_a;
    div_b_nx   = div_b;
    quo_nx     = quo;
    ovf_nx     = ovf;
    dbz_nx     = dbz;
    busy_nx    = busy_flag;
    done_nx    = 1'b0;
    write_a_nx = 1'b0;
    start_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (we) begin
            q_nx = '0;
            if (addr == ADDR_DIVIDEND) begin
              div_a_nx   = data;
              write_a_nx = 1'b1;
              done_nx    = 1'b1;
              state_nx   = S_WACK;
            end else if (addr == ADDR_DIVISOR) begin
              div_b_nx = data;
              start_nx = 1'b1;
              state_nx = S_LAUNCH;
            end else begin
              done_nx  = 1'b1;
              state_nx = S_WACK;
            end
          end else begin
            if (addr == ADDR_STATUS)        q_nx = status_word;
            else if (addr == ADDR_QUOTIENT) q_nx = quo;
            else                            q_nx = '0;
            done_nx  = 1'b1;
            state_nx = S_RESP;
          end
        end
      end
      S_WACK:   state_nx = S_IDLE;
      S_LAUNCH: begin
        busy_nx  = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Only the first done cycle is taken; its second cycle lands in RESP and is dropped.
        if (div_done) begin
          ovf_nx   = div_ovf;
          dbz_nx   = div_dbz;
          quo_nx   = (div_ovf || div_dbz) ? '0 : div_val;
          busy_nx  = 1'b0;
          q_nx     = '0;
          done_nx  = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      q           <= '0;
      div_a       <= '0;
      div_b       <= '0;
      quo         <= '0;
      ovf         <= 1'b0;
      dbz         <= 1'b0;
      busy_flag   <= 1'b0;
      done        <= 1'b0;
      div_write_a <= 1'b0;
      div_start   <= 1'b0;
    end else begin
      state       <= state_nx;
      q           <= q_nx;
      div_a       <= div_a_nx;
      div_b       <= div_b_nx;
      quo         <= quo_nx;
      ovf         <= ovf_nx;
      dbz         <= dbz_nx;
      busy_flag   <= busy_nx;
      done        <= done_nx;
      div_write_a <= write_a_nx;
      div_start   <= start_nx;
    end
  end

endmodule

// File: tb/tb_divider_bus_if.sv
// tb/tb_divider_bus_if.sv - directed bench for divider_bus_if with a Q16.16 divider model
module tb_divider_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data = 32'h0;
  logic [31:0] q;
  logic        done;
  logic        div_write_a;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_start;
  logic        div_busy, div_done, div_dbz, div_ovf;
  logic [31:0] div_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  divider_bus_if #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .addr(addr), .data(data),
    .q(q), .done(done), .div_write_a(div_write_a), .div_a(div_a), .div_b(div_b),
    .div_start(div_start), .div_busy(div_busy), .div_done(div_done),
    .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val)
  );

  // Divider model: errors report done on the cycle after start, normal divisions 5 cycles later.
  logic [31:0] m_a;
  logic [2:0]  m_timer;
  logic [1:0]  m_done_left;

  function automatic logic [33:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] num, den, res;
    if (b == 32'h0) return {2'b01, 32'h0};
    num = {{32{a[31]}}, a};
    num = num <<< 16;
    den = {{32{b[31]}}, b};
    res = num / den;
    if (res > 64'sh7FFFFFFF || res < -64'sh80000000) return {2'b10, 32'h0};
    return {2'b00, res[31:0]};
  endfunction

  always @(posedge clk) begin
    logic [33:0] r;
    if (rst) begin
      m_a <= 32'h0; m_timer <= 3'd0; m_done_left <= 2'd0;
      div_val <= 32'h0; div_dbz <= 1'b0; div_ovf <= 1'b0;
    end else begin
      if (m_done_left != 2'd0) m_done_left <= m_done_left - 2'd1;
      if (div_write_a) m_a <= div_a;
      if (div_start) begin
        r = model_div(m_a, div_b);
        div_ovf <= r[33];
        div_dbz <= r[32];
        div_val <= r[31:0];
        if (r[33] || r[32]) m_done_left <= 2'd2;
        else m_timer <= 3'd4;
      end else if (m_timer != 3'd0) begin
        m_timer <= m_timer - 3'd1;
        if (m_timer == 3'd1) m_done_left <= 2'd2;
      end
    end
  end

  assign div_done = (m_done_left != 2'd0);
  assign div_busy = (m_timer != 3'd0) || (m_done_left != 2'd0);

  // Event monitor, sampled mid-cycle.
  int cyc = 0;
  int last_done_cyc = -100;
  int n_launch = 0;
  int n_done = 0;
  int n_viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (div_start) begin
      n_launch++;
      if (cyc - last_done_cyc < 2) n_viol++;
    end
    if (div_done) last_done_cyc = cyc;
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus access starting in the current (IDLE) cycle; returns in the cycle after done.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rq, output int lat, output logic wa1,
                     output logic ds1, output logic bstable);
    logic [31:0] b1;
    start = 1'b1; we = w; addr = a; data = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; rq = 32'hDEAD_BEEF;
    wa1 = div_write_a; ds1 = div_start; b1 = div_b; bstable = 1'b1;
    for (int i = 1; i < 60; i++) begin
      if (div_b !== b1) bstable = 1'b0;
      if (done) begin
        lat = i; rq = q;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rq;
  int          lat;
  logic        wa1, ds1, bst;
  int          l0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", q, 32'h0);
    check("rst_ctl", {29'h0, done, div_write_a, div_start}, 32'h0);
    check("rst_div_a", div_a, 32'h0);
    check("rst_div_b", div_b, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    bus(1'b1, 2'd0, 32'h0007_0000, rq, lat, wa1, ds1, bst);
    check("dividend_lat", lat, 32'd1);
    check("dividend_write_a", {31'h0, wa1}, 32'd1);
    check("dividend_div_a", div_a, 32'h0007_0000);

    l0 = n_launch;
    bus(1'b1, 2'd1, 32'h0002_0000, rq, lat, wa1, ds1, bst);
    check("divisor_start_c1", {31'h0, ds1}, 32'd1);
    check("divisor_lat", lat, 32'd7);
    check("divisor_b_stable", {31'h0, bst}, 32'd1);
    check("divisor_one_launch", n_launch - l0, 32'd1);
    check("divisor_q_zero", rq, 32'h0);
    bus(1'b0, 2'd2, 32'h0, rq, lat, wa1, ds1, bst);
    check("read_quo_lat", lat, 32'd1);
    check("read_quo", rq, 32'h0003_8000);
    bus(1'b0, 2'd3, 32'h0, rq, lat, wa1, ds1, bst);
    check("read_status_ok", rq, 32'h0);

    bus(1'b1, 2'd1, 32'h0, rq, lat, wa1, ds1, bst);
    check("dbz_lat", lat, 32'd3);
    bus(1'b0, 2'd3, 32'h0, rq, lat, wa1, ds1, bst);
    check("dbz_status", rq, 32'h2);
    bus(1'b0, 2'd2, 32'h0, rq, lat, wa1, ds1, bst);
    check("dbz_quo", rq, 32'h0);

    bus(1'b1, 2'd0, 32'h8000_0000, rq, lat, wa1, ds1, bst);
    bus(1'b1, 2'd1, 32'h0000_0001, rq, lat, wa1, ds1, bst);
    check("ovf_lat", lat, 32'd3);
    bus(1'b0, 2'd3, 32'h0, rq, lat, wa1, ds1, bst);
    check("ovf_status", rq, 32'h4);
    bus(1'b0, 2'd2, 32'h0, rq, lat, wa1, ds1, bst);
    check("ovf_quo", rq, 32'h0);

    bus(1'b1, 2'd2, 32'h1234_5678, rq, lat, wa1, ds1, bst);
    check("ro_write_lat", lat, 32'd1);
    check("ro_write_no_a", {31'h0, wa1}, 32'd0);

    // Back-to-back DIVISOR writes with start held high.
    bus(1'b1, 2'd0, 32'h0007_0000, rq, lat, wa1, ds1, bst);
    l0 = n_launch; d0 = n_done; n_viol = 0;
    start = 1'b1; we = 1'b1; addr = 2'd1; data = 32'h0002_0000;
    repeat (60) @(posedge clk);
    #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("hold_no_viol", n_viol, 32'd0);
    check("hold_launched", {31'h0, (n_launch - l0) >= 5}, 32'd1);
    check("hold_done_per_launch", n_done - d0, n_launch - l0);
    bus(1'b0, 2'd2, 32'h0, rq, lat, wa1, ds1, bst);
    check("hold_quo", rq, 32'h0003_8000);

    // Reset while the divider is mid-division.
    start = 1'b1; we = 1'b1; addr = 2'd1; data = 32'h0002_0000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = n_done;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwait_ctl", {29'h0, done, div_write_a, div_start}, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("rstwait_no_done", n_done - d0, 32'd0);
    bus(1'b0, 2'd3, 32'h0, rq, lat, wa1, ds1, bst);
    check("rstwait_status", rq, 32'h0);
    bus(1'b1, 2'd0, 32'h0009_0000, rq, lat, wa1, ds1, bst);
    bus(1'b1, 2'd1, 32'h0003_0000, rq, lat, wa1, ds1, bst);
    check("after_rst_lat", lat, 32'd7);
    bus(1'b0, 2'd2, 32'h0, rq, lat, wa1, ds1, bst);
    check("after_rst_quo", rq, 32'h0003_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
